// File: rtl/arb_req_queue_pkg.sv
// Shared constants, types and helpers for the arbiter ingress queue.
//   N_DEF / DW_DEF / DEPTH_DEF : default requester count, data width, FIFO depth
//   src_t                      : source-ID type for the default requester count
//   lowest_set()               : priority one-hot-to-index, lowest set bit wins
package arb_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;

  // Widest request vector the index helper handles
  localparam int unsigned MAX_N = 32;
  localparam int unsigned IDX_W = $clog2(MAX_N);

  typedef logic [$clog2(N_DEF)-1:0] src_t;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_N-1:0] v);
    lowest_set = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/arb_req_queue_if.sv
// Client/arbiter/downstream bundle for arb_req_queue.
//   in_valid/in_data/in_ready : per-client push handshake, client i at [i*DW +: DW]
//   req/grant                 : level request to, one-hot grant from, the arbiter
//   out_valid/out_data/out_src/out_ready : single output stage with source ID
//   grant_err                 : sticky multi-hot grant flag
// slave modport is the queue side, master is the environment side.
interface arb_req_queue_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            grant_err;

  modport slave (
    input  in_valid, in_data, grant, out_ready,
    output in_ready, req, out_valid, out_data, out_src, grant_err
  );

  modport master (
    output in_valid, in_data, grant, out_ready,
    input  in_ready, req, out_valid, out_data, out_src, grant_err
  );
endinterface

// File: rtl/arb_req_queue_fifo.sv
// Show-ahead synchronous FIFO, one per requester.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write strobe and data (ignored when full)
//   pop        : read strobe (caller only pops when non-empty)
//   rdata      : head-of-queue word, combinational from the read pointer
//   count/full/empty : occupancy status
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-requester ingress queues feeding a round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   bus        : arb_req_queue_if.slave -- client pushes, req/grant to the
//                arbiter, registered output stage with source ID, grant_err
// A non-empty FIFO raises req; the granted FIFO (lowest index if multi-hot)
// pops into the output register when that stage can take a word.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  arb_req_queue_if.slave  bus
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] rdata [N];
  logic [CW-1:0] cnt   [N];
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic [N-1:0]  pop;
  logic [N-1:0]  req_w;
  logic [N-1:0]  sel;
  logic [SW-1:0] pop_idx;
  logic          stage_free;
  logic          pop_en;
  logic          multi_hot;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [SW-1:0] out_src_q,   out_src_d;
  logic          err_q,       err_d;

  // Per-client queues
  for (genvar i = 0; i < N; i++) begin : g_fifo
    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid[i]),
      .wdata (bus.in_data[i*DW +: DW]),
      .pop   (pop[i]),
      .rdata (rdata[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    // req depends only on stored occupancy, never on grant or in_valid
    assign req_w[i] = (cnt[i] != '0);
    assign pop[i]   = pop_en & (pop_idx == SW'(i)) & ~empty[i];
  end

  assign bus.in_ready = ~full;
  assign bus.req      = req_w;

  // Stale grants (to empty FIFOs) drop out here
  assign sel        = bus.grant & req_w;
  assign stage_free = ~out_valid_q | bus.out_ready;
  assign pop_en     = (sel != '0) & stage_free;
  assign pop_idx    = SW'(lowest_set(MAX_N'(sel)));
  assign multi_hot  = ((bus.grant & (bus.grant - N'(1))) != '0);

  // Output stage next-state
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    err_d       = err_q | multi_hot;
    if (pop_en) begin
      out_valid_d = 1'b1;
      out_data_d  = rdata[pop_idx];
      out_src_d   = pop_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.grant_err = err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: stimulus pushes expected {data,src}
// into a scoreboard when a grant is issued; a negedge monitor checks each
// accepted output word against it.
module tb_arb_req_queue;
  logic clk = 1'b0;
  logic rst_n;

  int vectors    = 0;
  int miscompares = 0;

  logic [9:0] exp_q [$];

  arb_req_queue_if #(.N(4), .DW(8)) bus ();

  arb_req_queue #(.N(4), .DW(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [7:0] d);
    bus.in_data[c*8 +: 8] = d;
  endtask

  // Scoreboard monitor: a word transfers at the next edge when valid & ready
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_word: got %0h/src %0d, expected nothing", bus.out_data, bus.out_src);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({bus.out_data, bus.out_src} !== e) begin
          miscompares++;
          $display("FAIL out_word: got %0h/src %0d, expected %0h/src %0d",
                   bus.out_data, bus.out_src, e[9:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.grant     = 4'b0000;
    bus.out_ready = 1'b1;

    // Reset with pushes attempted
    cyc();
    cyc();
    chk("rst_req",       32'(bus.req),       32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'hF);
    chk("rst_grant_err", 32'(bus.grant_err), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_src",   32'(bus.out_src),   32'h0);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_req", 32'(bus.req), 32'h0);

    // Single client, two words on client 2
    bus.in_valid = 4'b0100;
    set_data(2, 8'hA1);
    cyc();
    set_data(2, 8'hA2);
    cyc();
    bus.in_valid = 4'b0000;
    chk("c2_req", 32'(bus.req), 32'h4);
    bus.grant = 4'b0100;
    exp_q.push_back({8'hA1, 2'd2});
    cyc();
    chk("c2_latency_valid", 32'(bus.out_valid), 32'h1);
    chk("c2_latency_src",   32'(bus.out_src),   32'h2);
    exp_q.push_back({8'hA2, 2'd2});
    cyc();
    chk("c2_req_drained", 32'(bus.req[2]), 32'h0);
    bus.grant = 4'b0000;
    cyc();
    chk("c2_valid_clear", 32'(bus.out_valid), 32'h0);

    // Fill client 0, fifth word refused
    bus.in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_data(0, 8'(k));
      cyc();
    end
    chk("full_in_ready", 32'(bus.in_ready[0]), 32'h0);
    set_data(0, 8'h04);
    cyc();
    bus.in_valid = 4'b0000;
    chk("full_hold", 32'(bus.in_ready[0]), 32'h0);
    bus.grant = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({8'(k), 2'd0});
      cyc();
    end
    bus.grant = 4'b0000;
    cyc();
    chk("full_drained_req",   32'(bus.req[0]),      32'h0);
    chk("full_drained_ready", 32'(bus.in_ready[0]), 32'h1);

    // Backpressure with words still queued
    bus.in_valid = 4'b0001;
    set_data(0, 8'hB0); cyc();
    set_data(0, 8'hB1); cyc();
    set_data(0, 8'hB2); cyc();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    bus.grant     = 4'b0001;
    exp_q.push_back({8'hB0, 2'd0});
    cyc();
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    cyc();
    cyc();
    chk("bp_data_stable", 32'(bus.out_data), 32'hB0);
    chk("bp_req_held",    32'(bus.req[0]),   32'h1);
    bus.out_ready = 1'b1;
    exp_q.push_back({8'hB1, 2'd0});
    cyc();
    chk("bp_next_word", 32'(bus.out_data), 32'hB1);
    bus.grant = 4'b0000;
    cyc();
    bus.grant = 4'b0001;
    exp_q.push_back({8'hB2, 2'd0});
    cyc();
    bus.grant = 4'b0000;
    cyc();
    chk("bp_drained_req", 32'(bus.req[0]), 32'h0);

    // Stale grant: second grant hits an empty FIFO
    bus.in_valid = 4'b0010;
    set_data(1, 8'hC5);
    cyc();
    bus.in_valid = 4'b0000;
    bus.grant = 4'b0010;
    exp_q.push_back({8'hC5, 2'd1});
    cyc();
    cyc();
    bus.grant = 4'b0000;
    chk("stale_valid_low", 32'(bus.out_valid), 32'h0);
    chk("stale_data_hold", 32'(bus.out_data),  32'hC5);
    chk("stale_src_hold",  32'(bus.out_src),   32'h1);

    // Multi-hot grant honours lowest index and sets sticky error
    bus.in_valid = 4'b1010;
    set_data(1, 8'hD1);
    set_data(3, 8'hD3);
    cyc();
    bus.in_valid = 4'b0000;
    bus.grant = 4'b1010;
    exp_q.push_back({8'hD1, 2'd1});
    cyc();
    bus.grant = 4'b0000;
    chk("mh_grant_err", 32'(bus.grant_err), 32'h1);
    chk("mh_req",       32'(bus.req),       32'h8);
    chk("mh_src",       32'(bus.out_src),   32'h1);
    bus.grant = 4'b1000;
    exp_q.push_back({8'hD3, 2'd3});
    cyc();
    bus.grant = 4'b0000;
    cyc();
    chk("mh_err_sticky", 32'(bus.grant_err), 32'h1);
    chk("mh_req_empty",  32'(bus.req),       32'h0);

    // Asynchronous reset clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant_err", 32'(bus.grant_err), 32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_data",  32'(bus.out_data),  32'h0);
    chk("arst_req",       32'(bus.req),       32'h0);
    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Per-requester ingress queueing ahead of the 4-way round-robin arbiter.
- Each of N clients pushes words into a private FIFO. A non-empty FIFO raises its req bit toward the arbiter.
- The one-hot grant returned by the arbiter pops that FIFO into a single registered output stage with valid/ready and source ID.
- Converts bursty client traffic into the level req / one-hot grant interface the arbiter consumes.

Parameters:
- N, 4, number of requesters (req/grant width)
- DW, 8, data word width
- DEPTH, 4, entries per FIFO (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  N  per-client push strobe
- in_data  in  N*DW  per-client data; client i at bits [i*DW +: DW]
- in_ready  out  N  per-client FIFO not full
- req  out  N  request to arbiter; bit i = FIFO i non-empty
- grant  in  N  one-hot (or zero) grant from arbiter
- out_valid  out  1  output stage holds a word
- out_data  out  DW  output word
- out_src  out  $clog2(N)  index of the FIFO that supplied out_data
- out_ready  in  1  downstream accepts when out_valid & out_ready
- grant_err  out  1  sticky: multi-hot grant seen

Behaviour:
- Reset (async assert, sync release by clk): all FIFOs empty, pointers/counts 0.
  - Outputs at reset: req=0, in_ready=all 1, out_valid=0, out_data=0, out_src=0, grant_err=0.
- Push: in_valid[i] & in_ready[i] writes FIFO i at clock edge. in_ready[i] = count[i] != DEPTH.
- req[i] = count[i] != 0. This is a registered-state function, with no combinational path from grant or in_valid.
- Output-stage capacity: stage_free = !out_valid | out_ready.
- Pop condition: sel = grant & req.
  - If sel != 0 and stage_free, pop FIFO at the lowest set index of sel.
  - The popped word loads out_data, its index loads out_src, and out_valid goes to 1 next cycle.
  - Latency: grant cycle -> data visible on out_* next cycle.
- Stale grant: if the grant targets an empty FIFO (arbiter grant lags req by a cycle), nothing pops. out_valid clears if the current word is accepted.
- Backpressure: if !stage_free, no pop; grant is ignored that cycle and FIFO contents are held.
- Output accepted with no new pop: out_valid -> 0. out_data and out_src hold their last value.
- Multi-hot grant: only the lowest index is honoured; grant_err sets and stays 1 until reset.
- Simultaneous push and pop on the same FIFO:
  - Allowed in every state, including full.
  - Full: in_ready=0, so only the pop occurs.
  - Empty: the pushed word is not poppable the same cycle, because req was 0.
  - Count changes by push minus pop.
- FIFO pointers wrap modulo DEPTH; the count is kept separately, width $clog2(DEPTH)+1.
- Data ordering: FIFO order per client. No ordering guarantee across clients beyond grant order.
- Reset mid-operation: all queued data is discarded, outputs return to reset values immediately on rst_n low.

Decomposition:
- Package arb_pkg:
  - default N/DW/DEPTH constants
  - function for lowest-set-bit index (onehot-to-index with priority)
  - src-ID width typedef
- Sub-module sync_fifo (DW, DEPTH), instantiated N times:
  - ports clk, rst_n, push, wdata, pop, rdata, count, full, empty
  - rdata is combinational from the read pointer (show-ahead)
- Top module: req generation, pop select, output register, grant_err flag.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=4'b1111 -> req=0, out_valid=0, in_ready=4'b1111, grant_err=0. After release, no data is present from the reset window.
- Single client: push 8'hA1, 8'hA2 on client 2; drive grant=4'b0100 each cycle, out_ready=1 -> req[2]=1 for two pops. out_data sequence A1, A2 with out_src=2, each one cycle after its grant. req[2]=0 after the second pop.
- Full FIFO: push 5 words to client 0 with no grant -> in_ready[0]=0 after the 4th. The 5th is dropped by the bench handshake. Pop all 4 and confirm order 0,1,2,3.
- Backpressure: out_ready=0 with out_valid=1, grant=4'b0001, FIFO 0 holding 2 words -> no pop, count[0] stays 2, out_data stable. Raise out_ready -> the next word appears the following cycle.
- Stale grant: FIFO 1 holds 1 word; grant=4'b0010 for two consecutive cycles -> exactly one pop, second grant ignored, out_valid low after acceptance.
- Multi-hot grant: grant=4'b1010 with FIFOs 1 and 3 non-empty -> FIFO 1 pops, FIFO 3 untouched, grant_err=1 and held through subsequent normal traffic until reset.
